fnd_display_controller: RTL and testbench



---
 rtl/fnd_pkg.sv | 41 ++++
 rtl/fnd_bcd_decoder.sv | 11 +
 rtl/fnd_display_controller.sv | 74 +++++++
 tb/tb_fnd_display_controller.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
// Shared constants and the digit-to-segment mapping for the 4-digit common-anode FND.
// All patterns are active-low with bit order {dp,g,f,e,d,c,b,a}.
package fnd_pkg;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    localparam logic [3:0] COM_DIG0 = 4'b1110;
    localparam logic [3:0] COM_DIG1 = 4'b1101;
    localparam logic [3:0] COM_DIG2 = 4'b1011;
    localparam logic [3:0] COM_DIG3 = 4'b0111;

    // Codes 10..15 cannot come out of the decimal splitter; blank them anyway.
    function automatic logic [7:0] digit_to_seg(input logic [3:0] digit);
        logic [7:0] seg;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/fnd_bcd_decoder.sv
// Combinational decimal digit to active-low 7-segment pattern decoder.
module fnd_bcd_decoder
    import fnd_pkg::*;
(
    input  logic [3:0] digit,
    output logic [7:0] seg
);

    assign seg = digit_to_seg(digit);

endmodule

// File: rtl/fnd_display_controller.sv
// Multiplexed 4-digit FND driver: prescaled digit scan, decimal split of a 14-bit
// count, and active-low digit-enable / segment outputs with no added latency.
module fnd_display_controller
    import fnd_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int SCAN_HZ     = 1_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] counter,
    output logic [3:0]  fnd_com,
    output logic [7:0]  fnd_data
);

    // DIV_COUNT must be at least 2 so the prescaler has a real wrap point.
    localparam int DIV_COUNT = CLK_FREQ_HZ / SCAN_HZ;
    localparam int DIV_W     = (DIV_COUNT > 2) ? $clog2(DIV_COUNT) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);

    logic [DIV_W-1:0] div_cnt;
    logic             scan_tick;
    logic [1:0]       sel;
    logic [3:0]       d0, d1, d2, d3;
    logic [3:0]       cur_digit;

    assign scan_tick = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst) begin
            div_cnt <= '0;
            sel     <= 2'd0;
        end else begin
            div_cnt <= scan_tick ? '0 : div_cnt + 1'b1;
            if (scan_tick) begin
                sel <= sel + 2'd1;
            end
        end
    end

    always_comb begin
        fnd_com = COM_DIG0;
        case (sel)
            2'd0:    fnd_com = COM_DIG0;
            2'd1:    fnd_com = COM_DIG1;
            2'd2:    fnd_com = COM_DIG2;
            2'd3:    fnd_com = COM_DIG3;
            default: fnd_com = COM_DIG0;
        endcase
    end

    // Values above 9999 are not clamped; the thousands digit simply wraps mod 10.
    assign d0 = 4'(counter % 14'd10);
    assign d1 = 4'((counter / 14'd10) % 14'd10);
    assign d2 = 4'((counter / 14'd100) % 14'd10);
    assign d3 = 4'((counter / 14'd1000) % 14'd10);

    always_comb begin
        cur_digit = d0;
        case (sel)
            2'd0:    cur_digit = d0;
            2'd1:    cur_digit = d1;
            2'd2:    cur_digit = d2;
            2'd3:    cur_digit = d3;
            default: cur_digit = d0;
        endcase
    end

    fnd_bcd_decoder u_decoder (
        .digit (cur_digit),
        .seg   (fnd_data)
    );

endmodule

// File: tb/tb_fnd_display_controller.sv
// Scoreboard bench for fnd_display_controller with a 4-cycle scan period; the reference
// model counts edges since reset and picks the decimal digit arithmetically.
module tb_fnd_display_controller;

    localparam int CLK_HZ  = 100_000_000;
    localparam int SCAN_HZ = 25_000_000;
    localparam int DIV     = CLK_HZ / SCAN_HZ;

    logic        clk;
    logic        rst;
    logic [13:0] counter;
    logic [3:0]  fnd_com;
    logic [7:0]  fnd_data;

    logic [11:0] exp_q[$];
    string       phase;
    int          n_vec;
    int          n_err;
    int          edges_since_reset;
    bit          driver_done;

    // Segment patterns written out from the display's decode table.
    logic [7:0] seg_tab [10];

    fnd_display_controller #(
        .CLK_FREQ_HZ (CLK_HZ),
        .SCAN_HZ     (SCAN_HZ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .counter  (counter),
        .fnd_com  (fnd_com),
        .fnd_data (fnd_data)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        rst     = 1'b0;
        counter = 14'd1234;
    end

    function automatic logic [11:0] model_out(input int edges, input int value);
        int digit_pos;
        int pow10;
        int digit;
        digit_pos = (edges / DIV) % 4;
        pow10 = 1;
        for (int i = 0; i < digit_pos; i++) pow10 = pow10 * 10;
        digit = (value / pow10) % 10;
        return {~(4'b0001 << digit_pos), seg_tab[digit]};
    endfunction

    // driver: one clock per call; model advances on the edge, then new inputs are applied
    task automatic step(input logic r, input int value);
        @(posedge clk);
        if (rst === 1'b0) edges_since_reset = 0;
        else              edges_since_reset = edges_since_reset + 1;
        #1;
        rst     = r;
        counter = 14'(value);
        exp_q.push_back(model_out(edges_since_reset, value));
    endtask

    task automatic run(input logic r, input int value, input int cycles);
        for (int i = 0; i < cycles; i++) step(r, value);
    endtask

    // monitor: compares once per cycle on the falling edge
    initial begin
        logic [11:0] exp;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                n_vec++;
                if ({fnd_com, fnd_data} !== exp) begin
                    n_err++;
                    $display("FAIL %s t=%0t counter=%0d got com=%b data=%h exp com=%b data=%h",
                             phase, $time, counter, fnd_com, fnd_data, exp[11:8], exp[7:0]);
                end
            end
        end
    end

    initial begin
        int v;
        int wait_cycles;
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};
        n_vec = 0;
        n_err = 0;
        edges_since_reset = 0;
        driver_done = 1'b0;

        phase = "reset_hold";
        run(1'b0, 1234, 3);

        phase = "scan_1234";
        run(1'b1, 1234, 20);

        phase = "decoder_sweep";
        for (int d = 0; d < 10; d++) begin
            step(1'b0, d);
            run(1'b1, d, 3);
        end

        phase = "all_zero";
        step(1'b0, 0);
        run(1'b1, 0, 16);

        phase = "mid_scan_change";
        step(1'b0, 1234);
        run(1'b1, 1234, 8);
        run(1'b1, 9876, 4);

        phase = "out_of_range";
        step(1'b0, 16383);
        run(1'b1, 16383, 16);
        step(1'b0, 12345);
        run(1'b1, 12345, 16);

        phase = "reset_mid_scan";
        step(1'b0, 1234);
        run(1'b1, 1234, 13);
        step(1'b0, 1234);
        run(1'b1, 1234, 10);

        phase = "random";
        v = 1234;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) v = $urandom_range(0, 16383);
            step(($urandom_range(0, 24) == 0) ? 1'b0 : 1'b1, v);
        end

        driver_done = 1'b1;
        wait_cycles = 0;
        while (exp_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        @(posedge clk);
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain pending=%0d exp=0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
